// File: rtl/reg8_arb_ctrl.sv
// Two-requester round-robin arbiter in front of an 8-word register bank.
// Each granted access takes one IDLE (arbitrate/latch) cycle and one SERVE cycle.
module reg8_arb_ctrl #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [2:0]    add_a,
  input  logic [2:0]    add_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata,
  output logic [7:0]    wen,
  output logic          busy
);

  typedef enum logic {StIdle, StServe} state_e;

  state_e          state_q, state_d;
  logic            last_gnt_q;  // 0: A granted last, 1: B granted last
  logic            win_d, win_q;
  logic            we_q;
  logic [2:0]      add_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   bank_q [8];
  logic            any_req;
  logic            accept;

  assign any_req = req_a | req_b;
  assign accept  = (state_q == StIdle) && any_req;

  // Arbitration: a lone requester always wins; on collision the one not granted last wins.
  always_comb begin
    win_d = 1'b0;
    if (req_a && req_b) begin
      win_d = ~last_gnt_q;
    end else if (req_b) begin
      win_d = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StServe;
      StServe: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Winner's request is captured on SERVE entry so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      add_q      <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      last_gnt_q <= win_d;
      win_q      <= win_d;
      we_q       <= win_d ? we_b    : we_a;
      add_q      <= win_d ? add_b   : add_a;
      wdata_q    <= win_d ? wdata_b : wdata_a;
    end
  end

  // Register bank, written only through the decoded word enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wen[i]) begin
          bank_q[i] <= wdata_q;
        end
      end
    end
  end

  // FSM outputs
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    rvalid_a = 1'b0;
    rvalid_b = 1'b0;
    rdata    = '0;
    wen      = 8'h00;
    busy     = 1'b0;
    if (state_q == StServe) begin
      busy  = 1'b1;
      gnt_a = ~win_q;
      gnt_b = win_q;
      if (we_q) begin
        wen = 8'h01 << add_q;
      end else begin
        rvalid_a = ~win_q;
        rvalid_b = win_q;
        rdata    = bank_q[add_q];
      end
    end
  end

endmodule

// File: doc/reg8_arb_ctrl.md
REG8_ARB_CTRL -- requirements
Module: reg8_arb_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data word width in bits for the 8-word register bank.
REQ-002 The block SHALL have port clk, input, 1, the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req_a / req_b, input, 1 each, access request from requester A / B.
REQ-005 The block SHALL have ports we_a / we_b, input, 1 each, 1 = write and 0 = read, qualified by the matching req.
REQ-006 The block SHALL have ports add_a / add_b, input, 3 each, word address.
REQ-007 The block SHALL have ports wdata_a / wdata_b, input, DW each, write data.
REQ-008 The block SHALL have ports gnt_a / gnt_b, output, 1 each, one-cycle grant pulse marking the SERVE cycle for that requester.
REQ-009 The block SHALL have ports rvalid_a / rvalid_b, output, 1 each, read data valid for that requester.
REQ-010 The block SHALL have port rdata, output, DW, shared read data.
REQ-011 The block SHALL have port wen, output, 8, one-hot word enable of the word being written.
REQ-012 The block SHALL have port busy, output, 1, high while in SERVE.

Function
REQ-013 The block SHALL contain an 8 x DW register bank, written only through the decoded wen lines.
REQ-014 The FSM SHALL have exactly two states: IDLE and SERVE.
REQ-015 In IDLE with neither req high, the FSM SHALL stay in IDLE and all pulse outputs SHALL be 0.
REQ-016 In IDLE with any req high, the FSM SHALL pick a winner, latch its we/add/wdata, and go to SERVE on the next edge.
REQ-017 Exactly one req high SHALL win regardless of priority state.
REQ-018 Both req high SHALL be resolved round-robin: the requester not granted last wins; last_gnt updates on entry to SERVE.
REQ-019 In SERVE, the winner's gnt SHALL be 1 for exactly that cycle, busy SHALL be 1, and the FSM SHALL return to IDLE unconditionally on the next edge (max one access per 2 cycles).
REQ-020 A SERVE write SHALL drive wen[latched add] = 1 with all other bits 0, and the bank word SHALL update at the SERVE-ending edge.
REQ-021 A SERVE read SHALL drive rdata = bank[latched add] and the winner's rvalid = 1 during SERVE.
REQ-022 Whenever the winner's rvalid is 0, rdata SHALL be 0.
REQ-023 wen SHALL be all-zero on reads and in IDLE.
REQ-024 Requesters SHALL hold req and its qualifiers until gnt; changes to req/we/add/wdata during SERVE SHALL NOT affect the access in progress.
REQ-025 A req still high in the IDLE cycle after its own gnt SHALL be treated as a new request, with round-robin applied.
REQ-026 A read issued in the access immediately after a write to the same address SHALL return the newly written value.
REQ-027 gnt_a and gnt_b SHALL never be high together, and rvalid_a and rvalid_b SHALL never be high together.

Reset
REQ-028 While rst_n = 0, the block SHALL immediately force state = IDLE, last_gnt = B (so A has first priority), all bank words = 0, and gnt_*, rvalid_*, wen, busy and rdata = 0.
REQ-029 Reset asserted during SERVE SHALL abort the access; no bank word is modified.
REQ-030 After rst_n deasserts, the first edge SHALL be treated as IDLE.

Verification
REQ-031 Scenario (write/read): after reset, A writes add 5, data 0x3C; then A reads add 5 -> wen = 0x20 in the write SERVE; in the read SERVE, rdata = 0x3C and rvalid_a = 1.
REQ-032 Scenario (collision): A and B both request continuously from reset -> grants alternate A, B, A, B on every second cycle; gnt_a and gnt_b never overlap.
REQ-033 Scenario (single requester): B alone requests reads of add 0..7 after reset -> 8 grants to B, each returning 0x00, with no gnt_a.
REQ-034 Scenario (mid-access change): A writes add 2, data 0x11; during SERVE, add_a changes to 3 and wdata_a to 0xFF -> only word 2 becomes 0x11.
REQ-035 Scenario (reset during access): assert rst_n = 0 during a SERVE write of 0xAA to add 7 -> outputs clear immediately and a later read of add 7 returns 0x00.
REQ-036 Scenario (write-then-read): B writes 0x5A to add 4, then A reads add 4 in the next access -> rdata = 0x5A.
